coo_aggregation_engine: RTL and testbench

Parametrised GCN combination stage that sits between the transformation block and the argmax block. It buffers the transformed rows (FM×WM, one row per node) and walks a COO edge list once, accumulating neighbour rows per destination node. Optional self-loop and undirected modes are selected per run, and accumulation saturates. Aggregated rows are streamed out one node at a time over a valid/ready handshake.

---
 rtl/coo_aggregation_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_coo_aggregation_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coo_aggregation_engine.sv
// coo_aggregation_engine
// GCN combination stage: buffers one transformed row per node, walks a COO
// edge list once while accumulating neighbour rows per destination node
// (optional self-loop / undirected modes, saturating sums), then streams
// the aggregated rows out over a valid/ready handshake.
module coo_aggregation_engine #(
   parameter int NUM_NODES  = 6,
   parameter int NUM_EDGES  = 6,
   parameter int OUT_COLS   = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 16,
   parameter int NODE_BW    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
   parameter int EDGE_BW    = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  row_wr_en,
   input  logic [NODE_BW-1:0]                    row_wr_idx,
   input  logic [0:OUT_COLS-1][DATA_WIDTH-1:0]   FM_WM_Row,
   input  logic                                  done_trans,
   input  logic                                  self_loop_en,
   input  logic                                  undirected,
   output logic [EDGE_BW-1:0]                    coo_address,
   input  logic [0:1][NODE_BW-1:0]               coo_in,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [NODE_BW-1:0]                    out_node,
   output logic [0:OUT_COLS-1][ACC_WIDTH-1:0]    fm_wm_adj_out,
   output logic                                  busy,
   output logic                                  err_flag,
   output logic                                  done_comb
);

   typedef logic [0:OUT_COLS-1][DATA_WIDTH-1:0] row_t;
   typedef logic [0:OUT_COLS-1][ACC_WIDTH-1:0]  acc_row_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_EDGE  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                        state_r;
   logic [EDGE_BW-1:0]            coo_address_r;
   logic                          out_valid_r;
   logic [NODE_BW-1:0]            out_node_r;
   logic                          busy_r;
   logic                          err_flag_r;
   logic                          done_comb_r;
   logic                          self_loop_r;
   logic                          undirected_r;

   row_t     [NUM_NODES-1:0]      row_buf_r;
   acc_row_t [NUM_NODES-1:0]      acc_r;
   acc_row_t [NUM_NODES-1:0]      acc_init_s;
   acc_row_t [NUM_NODES-1:0]      acc_edge_s;

   row_t                          src_row_s;
   row_t                          dst_row_s;
   logic                          src_ok_s;
   logic                          dst_ok_s;
   logic                          edge_ok_s;
   logic                          self_edge_s;

   // Unsigned add of a zero-extended row element that clamps at all-ones.
   function automatic logic [ACC_WIDTH-1:0] sat_add(
      input logic [ACC_WIDTH-1:0]  a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [ACC_WIDTH:0] sum;
      sum = {1'b0, a} + (ACC_WIDTH+1)'(b);
      if (sum[ACC_WIDTH]) begin
         sat_add = '1;
      end else begin
         sat_add = sum[ACC_WIDTH-1:0];
      end
   endfunction

   assign coo_address = coo_address_r;
   assign out_valid   = out_valid_r;
   assign out_node    = out_node_r;
   assign busy        = busy_r;
   assign err_flag    = err_flag_r;
   assign done_comb   = done_comb_r;

   // Decode the current COO entry: fetch both endpoint rows and flag out-of-range nodes.
   always_comb begin
      src_row_s = '0;
      dst_row_s = '0;
      src_ok_s  = 1'b0;
      dst_ok_s  = 1'b0;
      for (int j = 0; j < NUM_NODES; j++) begin
         src_row_s = (coo_in[0] == NODE_BW'(j)) ? row_buf_r[j] : src_row_s;
         dst_row_s = (coo_in[1] == NODE_BW'(j)) ? row_buf_r[j] : dst_row_s;
         src_ok_s  = src_ok_s | (coo_in[0] == NODE_BW'(j));
         dst_ok_s  = dst_ok_s | (coo_in[1] == NODE_BW'(j));
      end
      edge_ok_s   = src_ok_s & dst_ok_s;
      self_edge_s = (coo_in[0] == coo_in[1]);
   end

   // Accumulator seed for INIT: own row when self-loops are on, zero otherwise.
   always_comb begin
      acc_init_s = '0;
      for (int i = 0; i < NUM_NODES; i++) begin
         for (int c = 0; c < OUT_COLS; c++) begin
            acc_init_s[i][c] = self_loop_r ? ACC_WIDTH'(row_buf_r[i][c]) : '0;
         end
      end
   end

   // Accumulator update for one EDGE cycle; the reverse direction is skipped on self-edges.
   always_comb begin
      acc_edge_s = acc_r;
      for (int i = 0; i < NUM_NODES; i++) begin
         for (int c = 0; c < OUT_COLS; c++) begin
            logic [DATA_WIDTH-1:0] add_dst;
            logic [DATA_WIDTH-1:0] add_src;
            add_dst = (edge_ok_s && (coo_in[1] == NODE_BW'(i))) ? src_row_s[c] : '0;
            add_src = (edge_ok_s && undirected_r && !self_edge_s &&
                       (coo_in[0] == NODE_BW'(i))) ? dst_row_s[c] : '0;
            acc_edge_s[i][c] = sat_add(sat_add(acc_r[i][c], add_dst), add_src);
         end
      end
   end

   // Present the accumulator of the current drain node, zero outside DRAIN.
   always_comb begin
      fm_wm_adj_out = '0;
      for (int j = 0; j < NUM_NODES; j++) begin
         fm_wm_adj_out = fm_wm_adj_out |
            (((state_r == ST_DRAIN) && (out_node_r == NODE_BW'(j))) ? acc_r[j] : '0);
      end
   end

   // Row buffer: written only while idle; slots beyond the node count are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_buf_r <= '0;
      end else if ((state_r == ST_IDLE) && row_wr_en) begin
         for (int j = 0; j < NUM_NODES; j++) begin
            if (row_wr_idx == NODE_BW'(j)) begin
               row_buf_r[j] <= FM_WM_Row;
            end else begin
               row_buf_r[j] <= row_buf_r[j];
            end
         end
      end else begin
         row_buf_r <= row_buf_r;
      end
   end

   // Accumulators: seeded in INIT, updated once per EDGE cycle, held otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_r <= '0;
      end else begin
         case (state_r)
            ST_INIT: acc_r <= acc_init_s;
            ST_EDGE: acc_r <= acc_edge_s;
            default: acc_r <= acc_r;
         endcase
      end
   end

   // Run controller with registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         coo_address_r <= '0;
         out_valid_r   <= 1'b0;
         out_node_r    <= '0;
         busy_r        <= 1'b0;
         err_flag_r    <= 1'b0;
         done_comb_r   <= 1'b0;
         self_loop_r   <= 1'b0;
         undirected_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_comb_r <= 1'b0;
               out_valid_r <= 1'b0;
               if (done_trans) begin
                  state_r       <= ST_INIT;
                  busy_r        <= 1'b1;
                  err_flag_r    <= 1'b0;
                  self_loop_r   <= self_loop_en;
                  undirected_r  <= undirected;
                  coo_address_r <= '0;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_INIT: begin
               state_r       <= ST_EDGE;
               coo_address_r <= '0;
            end
            ST_EDGE: begin
               if (!edge_ok_s) begin
                  err_flag_r <= 1'b1;
               end else begin
                  err_flag_r <= err_flag_r;
               end
               if (coo_address_r == EDGE_BW'(NUM_EDGES - 1)) begin
                  state_r       <= ST_DRAIN;
                  coo_address_r <= '0;
                  out_valid_r   <= 1'b1;
                  out_node_r    <= '0;
               end else begin
                  coo_address_r <= coo_address_r + EDGE_BW'(1);
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  if (out_node_r == NODE_BW'(NUM_NODES - 1)) begin
                     state_r     <= ST_DONE;
                     out_valid_r <= 1'b0;
                     out_node_r  <= '0;
                     done_comb_r <= 1'b1;
                  end else begin
                     out_node_r <= out_node_r + NODE_BW'(1);
                  end
               end else begin
                  out_node_r <= out_node_r;
               end
            end
            ST_DONE: begin
               state_r     <= ST_IDLE;
               done_comb_r <= 1'b0;
               busy_r      <= 1'b0;
            end
            default: begin
               state_r       <= ST_IDLE;
               coo_address_r <= '0;
               out_valid_r   <= 1'b0;
               out_node_r    <= '0;
               busy_r        <= 1'b0;
               done_comb_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coo_aggregation_engine.sv
// Self-checking bench for coo_aggregation_engine: table of run vectors with
// hand-computed key rows, a reference model feeding a scoreboard queue, and
// hand-written backpressure and mid-run reset sequences.
module tb_coo_aggregation_engine;

   localparam int NN  = 6;
   localparam int NE  = 6;
   localparam int OC  = 3;
   localparam int DW  = 16;
   localparam int AW  = 16;
   localparam int NBW = 3;
   localparam int EBW = 3;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    row_wr_en;
   logic [NBW-1:0]          row_wr_idx;
   logic [0:OC-1][DW-1:0]   fm_wm_row;
   logic                    done_trans;
   logic                    self_loop_en;
   logic                    undirected;
   logic [EBW-1:0]          coo_address;
   logic [0:1][NBW-1:0]     coo_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [NBW-1:0]          out_node;
   logic [0:OC-1][AW-1:0]   fm_wm_adj_out;
   logic                    busy;
   logic                    err_flag;
   logic                    done_comb;

   typedef struct packed {
      logic                 sat_rows;
      logic [0:5][2:0]      src;
      logic [0:5][2:0]      dst;
      logic                 sl;
      logic                 ud;
      logic                 exp_err;
      logic [0:2][15:0]     n0;
      logic [2:0]           chk_node;
      logic [0:2][15:0]     chk_row;
   } vec_t;

   typedef struct packed {
      logic [2:0]           node;
      logic [0:2][15:0]     row;
   } exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          hs_cnt  = 0;
   int          done_cnt = 0;
   exp_t        exp_q[$];
   logic [2:0]  src_tab[8];
   logic [2:0]  dst_tab[8];
   vec_t        vecs[5];

   coo_aggregation_engine #(
      .NUM_NODES(NN), .NUM_EDGES(NE), .OUT_COLS(OC), .DATA_WIDTH(DW),
      .ACC_WIDTH(AW), .NODE_BW(NBW), .EDGE_BW(EBW)
   ) dut (
      .clk(clk), .reset(reset), .row_wr_en(row_wr_en), .row_wr_idx(row_wr_idx),
      .FM_WM_Row(fm_wm_row), .done_trans(done_trans), .self_loop_en(self_loop_en),
      .undirected(undirected), .coo_address(coo_address), .coo_in(coo_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node),
      .fm_wm_adj_out(fm_wm_adj_out), .busy(busy), .err_flag(err_flag),
      .done_comb(done_comb)
   );

   always #5 clk = ~clk;

   // COO memory model: combinational lookup of the addressed entry
   always_comb coo_in = {src_tab[coo_address], dst_tab[coo_address]};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [0:2][15:0] row_of(input logic sat, input int i);
      logic [0:2][15:0] r;
      for (int c = 0; c < 3; c++) r[c] = sat ? 16'hFFF0 : 16'((c + 1) * (i + 1));
      return r;
   endfunction

   // Reference aggregation; node 0 and the vector's check node use hand values.
   task automatic push_expected(input vec_t v);
      int acc[6][3];
      logic [0:2][15:0] rs, rd;
      exp_t e;
      for (int i = 0; i < NN; i++) begin
         rs = row_of(v.sat_rows, i);
         for (int c = 0; c < OC; c++) acc[i][c] = v.sl ? int'(rs[c]) : 0;
      end
      for (int k = 0; k < NE; k++) begin
         int s, d;
         s = int'(v.src[k]);
         d = int'(v.dst[k]);
         if (s < NN && d < NN) begin
            rs = row_of(v.sat_rows, s);
            rd = row_of(v.sat_rows, d);
            for (int c = 0; c < OC; c++) begin
               acc[d][c] = acc[d][c] + int'(rs[c]);
               if (acc[d][c] > 65535) acc[d][c] = 65535;
               if (v.ud && s != d) begin
                  acc[s][c] = acc[s][c] + int'(rd[c]);
                  if (acc[s][c] > 65535) acc[s][c] = 65535;
               end
            end
         end
      end
      for (int i = 0; i < NN; i++) begin
         e.node = 3'(i);
         for (int c = 0; c < OC; c++) e.row[c] = 16'(acc[i][c]);
         if (i == 0) e.row = v.n0;
         else if (3'(i) == v.chk_node) e.row = v.chk_row;
         exp_q.push_back(e);
      end
   endtask

   // Scoreboard monitor: every presented row must match the queue head
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_row", 64'(out_node), 64'hFF);
         end else begin
            chk("sb_node", 64'(out_node), 64'(exp_q[0].node));
            chk("sb_row", 64'(fm_wm_adj_out), 64'(exp_q[0].row));
            if (out_ready) begin
               void'(exp_q.pop_front());
               hs_cnt++;
            end
         end
      end
      if (!reset && done_comb) done_cnt++;
   end

   task automatic run_vec(input vec_t v, input int bp_cycles, input int abort_cyc);
      int first_valid, done_at, bp_left;
      first_valid = -1;
      done_at     = -1;
      bp_left     = bp_cycles;
      for (int k = 0; k < 8; k++) begin
         src_tab[k] = (k < NE) ? v.src[k] : 3'd0;
         dst_tab[k] = (k < NE) ? v.dst[k] : 3'd0;
      end
      hs_cnt   = 0;
      done_cnt = 0;
      push_expected(v);
      // last row write shares the cycle with done_trans
      for (int i = 0; i < NN; i++) begin
         @(posedge clk); #2;
         row_wr_en  = 1'b1;
         row_wr_idx = 3'(i);
         fm_wm_row  = row_of(v.sat_rows, i);
         if (i == NN - 1) begin
            done_trans   = 1'b1;
            self_loop_en = v.sl;
            undirected   = v.ud;
         end
      end
      @(posedge clk); #2;
      row_wr_en    = 1'b0;
      done_trans   = 1'b0;
      self_loop_en = 1'b0;
      undirected   = 1'b0;
      out_ready    = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc > 1) begin
            @(posedge clk); #2;
            if (cyc == abort_cyc) begin
               reset = 1'b1;
               #1;
               chk("rst_out_valid", 64'(out_valid), 64'd0);
               chk("rst_busy", 64'(busy), 64'd0);
               chk("rst_done_comb", 64'(done_comb), 64'd0);
               chk("rst_adj_out", 64'(fm_wm_adj_out), 64'd0);
               chk("rst_out_node", 64'(out_node), 64'd0);
               chk("rst_err_flag", 64'(err_flag), 64'd0);
               exp_q.delete();
               @(posedge clk); #2;
               reset = 1'b0;
               done_cnt = 0;
               repeat (20) @(negedge clk);
               chk("rst_no_done", 64'(done_cnt), 64'd0);
               chk("rst_idle_busy", 64'(busy), 64'd0);
               return;
            end
            out_ready = 1'b1;
            if (bp_left > 0 && out_valid && out_node == 3'd2) begin
               out_ready = 1'b0;
               bp_left--;
            end
            if (bp_cycles > 0 && cyc == 4) begin
               row_wr_en  = 1'b1;
               row_wr_idx = 3'd5;
               fm_wm_row  = {3{16'hAAAA}};
               done_trans = 1'b1;
            end else begin
               row_wr_en  = 1'b0;
               done_trans = 1'b0;
            end
         end
         @(negedge clk);
         if (cyc == 1) begin
            chk("init_busy", 64'(busy), 64'd1);
            chk("init_err_clear", 64'(err_flag), 64'd0);
            chk("init_adj_zero", 64'(fm_wm_adj_out), 64'd0);
         end
         if (cyc >= 2 && cyc < 2 + NE) chk("coo_address", 64'(coo_address), 64'(cyc - 2));
         if (cyc == NE + 2) chk("err_flag_end_edge", 64'(err_flag), 64'(v.exp_err));
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (done_comb) begin
            done_at = cyc;
            break;
         end
      end
      chk("first_valid_cycle", 64'(first_valid), 64'(NE + 2));
      chk("done_comb_cycle", 64'(done_at), 64'(NE + NN + 2 + bp_cycles));
      @(negedge clk);
      chk("post_done_busy", 64'(busy), 64'd0);
      chk("done_one_pulse", 64'(done_comb), 64'd0);
      chk("handshakes", 64'(hs_cnt), 64'(NN));
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      // directed ring
      vecs[0] = '{1'b0, {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5}, {3'd1,3'd2,3'd3,3'd4,3'd5,3'd0},
                  1'b0, 1'b0, 1'b0, {16'd6,16'd12,16'd18}, 3'd1, {16'd1,16'd2,16'd3}};
      // entry 3 references node 7
      vecs[1] = '{1'b0, {3'd0,3'd1,3'd2,3'd7,3'd4,3'd5}, {3'd1,3'd2,3'd3,3'd1,3'd5,3'd0},
                  1'b0, 1'b0, 1'b1, {16'd6,16'd12,16'd18}, 3'd1, {16'd1,16'd2,16'd3}};
      // undirected + self-loop ring
      vecs[2] = '{1'b0, {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5}, {3'd1,3'd2,3'd3,3'd4,3'd5,3'd0},
                  1'b1, 1'b1, 1'b0, {16'd9,16'd18,16'd27}, 3'd3, {16'd12,16'd24,16'd36}};
      // undirected + self-loop with self-edge (2,2)
      vecs[3] = '{1'b0, {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5}, {3'd1,3'd2,3'd2,3'd4,3'd5,3'd0},
                  1'b1, 1'b1, 1'b0, {16'd9,16'd18,16'd27}, 3'd2, {16'd8,16'd16,16'd24}};
      // saturation: every edge 1 -> 0
      vecs[4] = '{1'b1, {3'd1,3'd1,3'd1,3'd1,3'd1,3'd1}, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
                  1'b0, 1'b0, 1'b0, {16'hFFFF,16'hFFFF,16'hFFFF}, 3'd1, {16'd0,16'd0,16'd0}};

      for (int k = 0; k < 8; k++) begin
         src_tab[k] = 3'd0;
         dst_tab[k] = 3'd0;
      end
      reset        = 1'b1;
      row_wr_en    = 1'b0;
      row_wr_idx   = 3'd0;
      fm_wm_row    = '0;
      done_trans   = 1'b0;
      self_loop_en = 1'b0;
      undirected   = 1'b0;
      out_ready    = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("reset_coo_address", 64'(coo_address), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_node", 64'(out_node), 64'd0);
      chk("reset_adj_out", 64'(fm_wm_adj_out), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_err_flag", 64'(err_flag), 64'd0);
      chk("reset_done_comb", 64'(done_comb), 64'd0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], 0, 0);
      // backpressure on node 2 for three cycles, plus ignored writes/starts while busy
      run_vec(vecs[0], 3, 0);
      // reset in DRAIN while node 2 is presented, then a clean rerun
      run_vec(vecs[1], 0, NE + 4);
      run_vec(vecs[0], 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
